// File: rtl/jtag_pkg.sv
// rtl/jtag_pkg.sv - shared types and helpers for the SIB/TDR segment network
package jtag_pkg;

    // Qualifier priority encoding shared with the TAP controller
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        CAPTURE = 2'd2,
        UPDATE  = 2'd3
    } qual_e;

    function automatic int seg_width(input int n_conf, input int n_scope);
        return n_conf + n_scope;
    endfunction

    function automatic int chan_idx_width(input int n_chan);
        return (n_chan > 1) ? $clog2(n_chan) : 1;
    endfunction

    function automatic qual_e decode_qual(input logic shift_q, input logic capture_q,
                                          input logic update_q);
        qual_e q;
        if (update_q)
            q = UPDATE;
        else if (capture_q)
            q = CAPTURE;
        else if (shift_q)
            q = SHIFT;
        else
            q = IDLE;
        return q;
    endfunction

endpackage

// File: rtl/jtag_seg.sv
// rtl/jtag_seg.sv - one channel: SIB bit, conf/scope TDR and shadowed conf outputs
module jtag_seg
    import jtag_pkg::*;
#(
    parameter int                N_CONF     = 8,
    parameter int                N_SCOPE    = 8,
    parameter logic [N_CONF-1:0] INIT_VALUE = '0,
    parameter int                SFI_W      = (N_SCOPE > 0) ? N_SCOPE : 1
) (
    input  logic              tck,
    input  logic              trst,
    input  qual_e             qual,
    input  logic              chain_in,
    input  logic              open_next,
    input  logic [SFI_W-1:0]  sfi,
    output logic              sib_bit,
    output logic              chain_out,
    output logic              sel,
    output logic [N_CONF-1:0] cfo,
    output logic              cfo_upd
);

    localparam int W = seg_width(N_CONF, N_SCOPE);

    logic [W-1:0] seg;
    logic [W-1:0] cap_val;
    logic [W-1:0] shift_val;

    generate
        if (N_SCOPE > 0) begin : g_scope
            assign cap_val = {sfi, cfo};
        end else begin : g_no_scope
            assign cap_val = cfo;
        end
        if (W > 1) begin : g_wide
            assign shift_val = {sib_bit, seg[W-1:1]};
        end else begin : g_single
            assign shift_val = sib_bit;
        end
    endgenerate

    // A closed segment is bypassed: the SIB bit feeds the next channel directly
    assign chain_out = sel ? seg[0] : sib_bit;

    always_ff @(posedge tck) begin
        if (trst) begin
            sib_bit <= 1'b0;
            sel     <= 1'b0;
            seg     <= W'(INIT_VALUE);
            cfo     <= INIT_VALUE;
            cfo_upd <= 1'b0;
        end else begin
            cfo_upd <= 1'b0;
            case (qual)
                UPDATE: begin
                    // Reload uses the select value from before this update
                    if (sel) begin
                        cfo     <= seg[N_CONF-1:0];
                        cfo_upd <= 1'b1;
                    end
                    sel     <= open_next;
                    sib_bit <= open_next;
                end
                CAPTURE: begin
                    sib_bit <= sel;
                    if (sel)
                        seg <= cap_val;
                end
                SHIFT: begin
                    sib_bit <= chain_in;
                    if (sel)
                        seg <= shift_val;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/jtag_sib_network.sv
// rtl/jtag_sib_network.sv - N_CHAN SIB-gated TDR segments chained between tdi and tdo
module jtag_sib_network
    import jtag_pkg::*;
#(
    parameter int                N_CHAN     = 4,
    parameter int                N_CONF     = 8,
    parameter int                N_SCOPE    = 8,
    parameter logic [N_CONF-1:0] INIT_VALUE = '0,
    parameter bit                MUTEX      = 1'b0
) (
    input  logic                                          tck,
    input  logic                                          trst,
    input  logic                                          shift,
    input  logic                                          capture,
    input  logic                                          update,
    input  logic                                          tdi,
    output logic                                          tdo,
    input  logic [N_CHAN*((N_SCOPE > 0) ? N_SCOPE : 1)-1:0] sfi,
    output logic [N_CHAN*N_CONF-1:0]                      cfo,
    output logic [N_CHAN-1:0]                             cfo_upd,
    output logic [N_CHAN-1:0]                             select
);

    localparam int SFI_W = (N_SCOPE > 0) ? N_SCOPE : 1;

    qual_e             qual;
    logic [N_CHAN-1:0] sib_bits;
    logic [N_CHAN-1:0] open_next;
    logic [N_CHAN:0]   chain;

    assign qual     = decode_qual(shift, capture, update);
    assign chain[0] = tdi;
    assign tdo      = chain[N_CHAN];

    // x & -x isolates the lowest set bit, so the lowest requested channel wins
    generate
        if (MUTEX) begin : g_mutex
            assign open_next = sib_bits & (-sib_bits);
        end else begin : g_open_all
            assign open_next = sib_bits;
        end
    endgenerate

    generate
        for (genvar k = 0; k < N_CHAN; k++) begin : g_chan
            jtag_seg #(
                .N_CONF     (N_CONF),
                .N_SCOPE    (N_SCOPE),
                .INIT_VALUE (INIT_VALUE),
                .SFI_W      (SFI_W)
            ) u_seg (
                .tck       (tck),
                .trst      (trst),
                .qual      (qual),
                .chain_in  (chain[k]),
                .open_next (open_next[k]),
                .sfi       (sfi[k*SFI_W +: SFI_W]),
                .sib_bit   (sib_bits[k]),
                .chain_out (chain[k+1]),
                .sel       (select[k]),
                .cfo       (cfo[k*N_CONF +: N_CONF]),
                .cfo_upd   (cfo_upd[k])
            );
        end
    endgenerate

endmodule

// File: doc/jtag_sib_network.md
Name: jtag_sib_network

Overview:
- Parametrised IJTAG-style segment network with N_CHAN identical channels, each a segment-insertion bit (SIB) followed by a test data register (TDR) made of conf and scope bits.
- Replaces hand-instantiated SIB/TDR chains in test-controller tops. Sits behind the TAP FSM, which drives shift/capture/update.
- New versus the previous generation: shadowed conf outputs with per-channel update pulses, optional mutually-exclusive channel opening, and a configurable reset value per channel.

Parameters:
- N_CHAN, 4, number of channels (1..16).
- N_CONF, 8, conf bits per channel (>=1).
- N_SCOPE, 8, scope/status bits per channel (0 allowed: no scope bits).
- INIT_VALUE, 0, reset value of every channel's conf shift bits and cfo shadow (N_CONF bits).
- MUTEX, 0, 1 = at most one channel open; the lowest requested index wins.

Ports:
- tck  input  1  test clock; all state on its rising edge.
- trst  input  1  synchronous active-high reset.
- shift  input  1  Shift-DR qualifier (level).
- capture  input  1  Capture-DR qualifier (one cycle).
- update  input  1  Update-DR qualifier (one cycle).
- tdi  input  1  serial in.
- tdo  output  1  serial out.
- sfi  input  N_CHAN*N_SCOPE  scope inputs; channel k at [k*N_SCOPE +: N_SCOPE]; unused if N_SCOPE=0.
- cfo  output  N_CHAN*N_CONF  shadowed conf outputs; channel k at [k*N_CONF +: N_CONF].
- cfo_upd  output  N_CHAN  one-cycle pulse: channel k cfo just reloaded.
- select  output  N_CHAN  channel open (SIB latched) flags.

Behaviour:
- Reset, synchronous on trst=1:
  - SIB shift bits = 0, select = 0.
  - Conf shift bits = INIT_VALUE, cfo = INIT_VALUE for all channels.
  - Scope shift bits = 0, cfo_upd = 0.
- Reset dominates every qualifier. Reset during a shift aborts it with no cfo_upd.
- Qualifier priority: trst > update > capture > shift. Simultaneous capture and shift: capture only.
- Chain order:
  - tdi -> SIB0 -> [seg0 if select[0]] -> SIB1 -> ... -> SIB(N_CHAN-1) -> [seg(N_CHAN-1) if select] -> tdo.
  - Segment k is seg[W-1:0], W = N_CONF+N_SCOPE. Conf bits occupy [N_CONF-1:0]; scope bits occupy [W-1:N_CONF].
- Shift (shift=1):
  - Each SIB bit takes its chain input.
  - Each open segment does seg <= {in, seg[W-1:1]}; its output is seg[0].
  - Closed segments hold and are bypassed.
- tdo is combinational from the last chain element's registered bit; no extra retiming (falling-edge retiming belongs to the TAP). Chain length = N_CHAN + W * popcount(select).
- Capture (capture=1), open segments only:
  - Conf bits load the current cfo (readback).
  - Scope bits load sfi.
  - SIB bits load the current select.
  - Closed segments hold.
- Update (update=1):
  - For each channel k with select[k]=1 before the update: cfo_k <= seg_k[N_CONF-1:0] and cfo_upd[k] = 1 in the following cycle.
  - Then select <= SIB shift bits. With MUTEX=1 and several bits set, only the lowest set index is opened and the SIB shift bits are rewritten to match.
  - Channels opened by this update get no cfo reload.
- cfo is stable outside update cycles: no glitches during shift.
- cfo_upd is a single-cycle pulse. Back-to-back updates give back-to-back pulses.

Decomposition:
- Package jtag_pkg: function seg_width(N_CONF, N_SCOPE), chan-index width constant clog2(N_CHAN), and the qualifier-priority encoding enum (IDLE/SHIFT/CAPTURE/UPDATE) shared with the TAP.
- Sub-module jtag_seg: one SIB plus TDR plus cfo shadow, instantiated N_CHAN times in a generate loop.
- Top-level logic: MUTEX arbitration and the chain concatenation.

Test Plan:
All cases use N_CHAN=4, N_CONF=4, N_SCOPE=8, INIT_VALUE=4'h3 unless stated.
- Reset, then shift 8 bits 1,0,1,1,0,0,0,0 -> first 4 tdo bits are 0; next 4 bits reproduce 1,0,1,1; cfo = 16'h3333; select = 0.
- Shift SIB pattern opening channel 2 only, then pulse update -> select = 4'b0100; chain length measured at 16 by a walking-1 flush.
- With channel 2 open, shift conf 4'hA and update -> cfo[11:8] = 4'hA; cfo_upd = 4'b0100 for exactly one cycle; other cfo nibbles stay 4'h3.
- Capture with sfi[23:16] = 8'h5C, then shift 16 -> tdo emits SIB3 bit, then A (LSB first: 0,1,0,1), then 5C LSB first, then SIB2, SIB1, SIB0.
- MUTEX=1: request channels 0 and 3 in one update -> select = 4'b0001. With MUTEX=0 -> select = 4'b1001, chain length 28.
- trst asserted mid-shift and simultaneously with update -> next cycle select = 0, cfo = INIT_VALUE, cfo_upd = 0; capture+shift together loads without shifting.
